// File: rtl/spgd_pert_sequencer.sv
// spgd_pert_sequencer: sequences one two-channel SPGD loop around a free-running
// perturbation PRNG: drive U+P, measure J+, drive U-P, measure J-, update U.
module spgd_pert_sequencer #(
  parameter int FP_WIDTH      = 64,
  parameter int INT_WIDTH     = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int ITER_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_WIDTH-1:0] n_iter,
  input  logic [FP_WIDTH-1:0]   u_init,
  input  logic [FP_WIDTH-1:0]   GAIN,
  input  logic [FP_WIDTH-1:0]   PERT_A,
  input  logic [FP_WIDTH-1:0]   PERT_B,
  output logic                  meas_req,
  input  logic                  meas_valid,
  input  logic [FP_WIDTH-1:0]   meas_data,
  output logic [FP_WIDTH-1:0]   DRIVE_A,
  output logic [FP_WIDTH-1:0]   DRIVE_B,
  output logic [FP_WIDTH-1:0]   U_A,
  output logic [FP_WIDTH-1:0]   U_B,
  output logic [ITER_WIDTH-1:0] iter_cnt,
  output logic                  busy,
  output logic                  done
);

  localparam int NCH = 2;
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);

  typedef logic [FP_WIDTH-1:0]          fp_t;
  typedef logic [NCH-1:0][FP_WIDTH-1:0] ch_t;

  localparam fp_t MAX_V = {1'b0, {(FP_WIDTH-1){1'b1}}};
  localparam fp_t MIN_V = {1'b1, {(FP_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_POS_SETTLE, S_POS_MEAS,
    S_NEG_SETTLE, S_NEG_MEAS, S_UPD1, S_UPD2
  } state_e;

  // Saturating signed add/subtract: one guard bit exposes overflow.
  function automatic fp_t sat_sum(input fp_t a, input fp_t b, input logic sub);
    logic [FP_WIDTH:0] s;
    if (sub) s = {a[FP_WIDTH-1], a} - {b[FP_WIDTH-1], b};
    else     s = {a[FP_WIDTH-1], a} + {b[FP_WIDTH-1], b};
    if (s[FP_WIDTH] != s[FP_WIDTH-1]) return s[FP_WIDTH] ? MIN_V : MAX_V;
    return s[FP_WIDTH-1:0];
  endfunction

  // Fixed-point multiply: full product, keep the Q-format window, clamp if the
  // bits above the window are not a pure sign extension.
  function automatic fp_t sat_mul(input fp_t a, input fp_t b);
    logic signed [2*FP_WIDTH-1:0] ax, bx, p;
    logic [INT_WIDTH:0]           hi;
    ax = {{FP_WIDTH{a[FP_WIDTH-1]}}, a};
    bx = {{FP_WIDTH{b[FP_WIDTH-1]}}, b};
    p  = ax * bx;
    hi = p[2*FP_WIDTH-1 -: INT_WIDTH+1];
    if (!(&hi) && (|hi)) return p[2*FP_WIDTH-1] ? MIN_V : MAX_V;
    return p[2*FP_WIDTH-1-INT_WIDTH -: FP_WIDTH];
  endfunction

  state_e                state_q, state_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  ch_t                   u_q, u_d, drv_q, drv_d, p_q, p_d;
  fp_t                   gain_q, gain_d, g_q, g_d, jp_q, jp_d, jn_q, jn_d;
  logic [ITER_WIDTH-1:0] n_iter_q, n_iter_d, iter_q, iter_d, iter_nxt;
  logic                  meas_req_q, meas_req_d, done_q, done_d;

  ch_t pert_in, drv_pos, drv_neg, u_upd;
  assign pert_in  = {PERT_B, PERT_A};
  assign iter_nxt = iter_q + ITER_WIDTH'(1);

  // Per-channel datapath: positive/negative drive and the gradient update.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign drv_pos[c] = sat_sum(u_q[c], pert_in[c], 1'b0);
    assign drv_neg[c] = sat_sum(u_q[c], p_q[c], 1'b1);
    assign u_upd[c]   = sat_sum(u_q[c], sat_mul(g_q, p_q[c]), 1'b0);
  end

  // Next-state and datapath control; abort overrides everything outside IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    u_d        = u_q;
    drv_d      = drv_q;
    p_d        = p_q;
    gain_d     = gain_q;
    g_d        = g_q;
    jp_d       = jp_q;
    jn_d       = jn_q;
    n_iter_d   = n_iter_q;
    iter_d     = iter_q;
    meas_req_d = meas_req_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        if (n_iter != '0) begin
          u_d      = {u_init, u_init};
          drv_d    = {u_init, u_init};
          gain_d   = GAIN;
          n_iter_d = n_iter;
          iter_d   = '0;
          state_d  = S_CAPTURE;
        end else begin
          done_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        p_d     = pert_in;
        drv_d   = drv_pos;
        cnt_d   = '0;
        state_d = S_POS_SETTLE;
      end
      S_POS_SETTLE, S_NEG_SETTLE: begin
        if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          meas_req_d = 1'b1;
          state_d    = (state_q == S_POS_SETTLE) ? S_POS_MEAS : S_NEG_MEAS;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      S_POS_MEAS: if (meas_req_q && meas_valid) begin
        jp_d       = meas_data;
        meas_req_d = 1'b0;
        drv_d      = drv_neg;
        cnt_d      = '0;
        state_d    = S_NEG_SETTLE;
      end
      S_NEG_MEAS: if (meas_req_q && meas_valid) begin
        jn_d       = meas_data;
        meas_req_d = 1'b0;
        state_d    = S_UPD1;
      end
      S_UPD1: begin
        g_d     = sat_mul(gain_q, sat_sum(jp_q, jn_q, 1'b1));
        state_d = S_UPD2;
      end
      S_UPD2: begin
        u_d    = u_upd;
        drv_d  = u_upd;
        iter_d = iter_nxt;
        if (iter_nxt == n_iter_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      u_d        = u_q;
      drv_d      = u_q;
      iter_d     = iter_q;
      meas_req_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State register with synchronous reset of every flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      u_q        <= '0;
      drv_q      <= '0;
      p_q        <= '0;
      gain_q     <= '0;
      g_q        <= '0;
      jp_q       <= '0;
      jn_q       <= '0;
      n_iter_q   <= '0;
      iter_q     <= '0;
      meas_req_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      u_q        <= u_d;
      drv_q      <= drv_d;
      p_q        <= p_d;
      gain_q     <= gain_d;
      g_q        <= g_d;
      jp_q       <= jp_d;
      jn_q       <= jn_d;
      n_iter_q   <= n_iter_d;
      iter_q     <= iter_d;
      meas_req_q <= meas_req_d;
      done_q     <= done_d;
    end
  end

  assign DRIVE_A  = drv_q[0];
  assign DRIVE_B  = drv_q[1];
  assign U_A      = u_q[0];
  assign U_B      = u_q[1];
  assign iter_cnt = iter_q;
  assign meas_req = meas_req_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_spgd_pert_sequencer.sv
// Directed bench for spgd_pert_sequencer (SETTLE_CYCLES=2, Q16.48) with a
// scoreboard of expected drive/control values built from a behavioural model.
module tb_spgd_pert_sequencer;
  localparam logic [63:0] ONE     = 64'h0001_0000_0000_0000;
  localparam logic [63:0] NEG_ONE = 64'hFFFF_0000_0000_0000;
  localparam logic [63:0] HALF    = 64'h0000_8000_0000_0000;
  localparam logic [63:0] QTR     = 64'h0000_4000_0000_0000;
  localparam logic [63:0] M_QTR   = 64'hFFFF_C000_0000_0000;
  localparam logic [63:0] M_8TH   = 64'hFFFF_E000_0000_0000;
  localparam logic [63:0] BIG     = 64'h7FFF_0000_0000_0000;
  localparam logic signed [127:0] MAXL = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MINL = -128'sh8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst, start, abort, meas_valid, meas_req, busy, done;
  logic [15:0] n_iter, iter_cnt;
  logic [63:0] u_init, GAIN, PERT_A, PERT_B, meas_data, DRIVE_A, DRIVE_B, U_A, U_B;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, start_cyc = 0;

  typedef struct { logic [63:0] pa, pb, na, nb, ua, ub; } exp_t;
  exp_t sb[$];
  logic [63:0] mu_a, mu_b, mgain;

  spgd_pert_sequencer #(.FP_WIDTH(64), .INT_WIDTH(16), .SETTLE_CYCLES(2), .ITER_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_iter(n_iter),
    .u_init(u_init), .GAIN(GAIN), .PERT_A(PERT_A), .PERT_B(PERT_B),
    .meas_req(meas_req), .meas_valid(meas_valid), .meas_data(meas_data),
    .DRIVE_A(DRIVE_A), .DRIVE_B(DRIVE_B), .U_A(U_A), .U_B(U_B),
    .iter_cnt(iter_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Behavioural reference arithmetic in wide signed integers.
  function automatic logic [63:0] clamp(input logic signed [127:0] v);
    if (v > MAXL) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (v < MINL) return 64'h8000_0000_0000_0000;
    return v[63:0];
  endfunction
  function automatic logic [63:0] m_add(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] xa, xb;
    xa = $signed(a); xb = $signed(b);
    return clamp(xa + xb);
  endfunction
  function automatic logic [63:0] m_sub(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] xa, xb;
    xa = $signed(a); xb = $signed(b);
    return clamp(xa - xb);
  endfunction
  function automatic logic [63:0] m_mul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] xa, xb;
    xa = $signed(a); xb = $signed(b);
    return clamp((xa * xb) >>> 48);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Push the expected drive and control values for one iteration.
  task automatic plan(input logic [63:0] pa, pb, jp, jn);
    exp_t e;
    logic [63:0] g;
    e.pa = m_add(mu_a, pa); e.pb = m_add(mu_b, pb);
    e.na = m_sub(mu_a, pa); e.nb = m_sub(mu_b, pb);
    g    = m_mul(mgain, m_sub(jp, jn));
    mu_a = m_add(mu_a, m_mul(g, pa));
    mu_b = m_add(mu_b, m_mul(g, pb));
    e.ua = mu_a; e.ub = mu_b;
    sb.push_back(e);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (meas_req !== 1'b1 && n < 60) begin tick; n++; end
    chk(tag, {63'b0, meas_req}, 64'd1);
  endtask

  task automatic start_run(input logic [15:0] n, input logic [63:0] ui, g);
    u_init = ui; GAIN = g; n_iter = n; start = 1'b1;
    mu_a = ui; mu_b = ui; mgain = g;
    tick;
    start = 1'b0; start_cyc = cyc;
    chk("start_busy", {63'b0, busy}, 64'd1);
    chk("start_u_a", U_A, ui);
    chk("start_drive_b", DRIVE_B, ui);
    chk("start_iter", {48'b0, iter_cnt}, 64'd0);
  endtask

  // One full iteration with handshakes; optionally pokes start while busy.
  task automatic do_iter(input logic [63:0] pa, pb, jp, jn, input int wait_pos,
                         input logic poke, input logic [15:0] k, input logic last);
    exp_t e;
    PERT_A = pa; PERT_B = pb;
    plan(pa, pb, jp, jn);
    if (poke) begin start = 1'b1; n_iter = 16'd9; u_init = 64'h0123_4567_89AB_CDEF; end
    wait_req("pos_req");
    start = 1'b0;
    e = sb.pop_front();
    chk("drive_pos_a", DRIVE_A, e.pa);
    chk("drive_pos_b", DRIVE_B, e.pb);
    PERT_A = ~pa; PERT_B = ~pb;
    for (int i = 0; i < wait_pos; i++) begin
      tick;
      chk("req_hold", {63'b0, meas_req}, 64'd1);
      chk("drive_hold", DRIVE_A, e.pa);
    end
    meas_valid = 1'b1; meas_data = jp;
    tick;
    chk("pos_req_drop", {63'b0, meas_req}, 64'd0);
    meas_data = 64'hDEAD_BEEF_0000_0000;
    tick;
    meas_valid = 1'b0;
    wait_req("neg_req");
    chk("drive_neg_a", DRIVE_A, e.na);
    chk("drive_neg_b", DRIVE_B, e.nb);
    meas_valid = 1'b1; meas_data = jn;
    tick;
    meas_valid = 1'b0; meas_data = '0;
    chk("neg_req_drop", {63'b0, meas_req}, 64'd0);
    tick; tick;
    chk("iter_cnt", {48'b0, iter_cnt}, {48'b0, k});
    chk("u_a", U_A, e.ua);
    chk("u_b", U_B, e.ub);
    chk("drive_upd_a", DRIVE_A, e.ua);
    chk("drive_upd_b", DRIVE_B, e.ub);
    chk("done_flag", {63'b0, done}, {63'b0, last});
    chk("busy_flag", {63'b0, busy}, {63'b0, !last});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_drive_a"}, DRIVE_A, 64'd0);
    chk({tag, "_drive_b"}, DRIVE_B, 64'd0);
    chk({tag, "_u_a"}, U_A, 64'd0);
    chk({tag, "_u_b"}, U_B, 64'd0);
    chk({tag, "_iter"}, {48'b0, iter_cnt}, 64'd0);
    chk({tag, "_req"}, {63'b0, meas_req}, 64'd0);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_done"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    exp_t e;
    int dc0;
    logic [63:0] ua_keep;
    rst = 1'b1; start = 1'b0; abort = 1'b0; meas_valid = 1'b0;
    n_iter = '0; u_init = '0; GAIN = '0; PERT_A = '0; PERT_B = '0; meas_data = '0;
    repeat (3) tick;
    chk_reset_outputs("por");
    rst = 1'b0;
    tick;

    // Basic single iteration with zero-wait metric.
    PERT_A = HALF; PERT_B = M_QTR;
    start_run(16'd1, 64'd0, ONE);
    do_iter(HALF, M_QTR, 2 * ONE, ONE, 0, 1'b0, 16'd1, 1'b1);
    chk("latency_1iter", 64'(cyc - start_cyc), 64'd9);
    tick;
    chk("done_pulse_end", {63'b0, done}, 64'd0);

    // Reset asserted for 3 cycles while waiting in POS_MEAS.
    PERT_A = QTR; PERT_B = QTR;
    start_run(16'd2, ONE, ONE);
    wait_req("rst_req");
    rst = 1'b1; meas_valid = 1'b1; meas_data = ONE;
    repeat (3) tick;
    meas_valid = 1'b0;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    tick;
    chk("post_rst_busy", {63'b0, busy}, 64'd0);
    chk("post_rst_req", {63'b0, meas_req}, 64'd0);

    // Metric held off for 10 cycles in POS_MEAS.
    PERT_A = QTR; PERT_B = M_8TH;
    start_run(16'd1, ONE, HALF);
    do_iter(QTR, M_8TH, 3 * ONE, NEG_ONE, 10, 1'b0, 16'd1, 1'b1);
    chk("latency_wait10", 64'(cyc - start_cyc), 64'd19);

    // Drive and control saturation near full scale.
    PERT_A = 2 * ONE; PERT_B = NEG_ONE;
    start_run(16'd1, BIG, ONE);
    do_iter(2 * ONE, NEG_ONE, 3 * ONE, 2 * ONE, 0, 1'b0, 16'd1, 1'b1);
    chk("sat_u_a_const", U_A, 64'h7FFF_FFFF_FFFF_FFFF);

    // Gain product saturation.
    PERT_A = HALF; PERT_B = NEG_ONE;
    start_run(16'd1, 64'd0, BIG);
    do_iter(HALF, NEG_ONE, 64'h0064_0000_0000_0000, 64'hFF9C_0000_0000_0000, 0, 1'b0, 16'd1, 1'b1);
    chk("gsat_u_b_const", U_B, 64'h8000_0000_0000_0001);

    // Abort coinciding with meas_valid in NEG_MEAS.
    PERT_A = HALF; PERT_B = QTR;
    start_run(16'd1, ONE, ONE);
    plan(HALF, QTR, 2 * ONE, ONE);
    wait_req("abort_pos_req");
    e = sb.pop_front();
    chk("abort_drive_pos", DRIVE_A, e.pa);
    meas_valid = 1'b1; meas_data = 2 * ONE;
    tick;
    meas_valid = 1'b0;
    wait_req("abort_neg_req");
    chk("abort_drive_neg", DRIVE_B, e.nb);
    dc0 = done_cnt;
    abort = 1'b1; meas_valid = 1'b1; meas_data = ONE;
    tick;
    abort = 1'b0; meas_valid = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_req", {63'b0, meas_req}, 64'd0);
    chk("abort_drive_a", DRIVE_A, ONE);
    chk("abort_drive_b", DRIVE_B, ONE);
    chk("abort_u_a", U_A, ONE);
    chk("abort_iter", {48'b0, iter_cnt}, 64'd0);
    tick; tick;
    chk("abort_no_done", 64'(done_cnt - dc0), 64'd0);

    // Three-iteration run with a start pulse while busy.
    dc0 = done_cnt;
    PERT_A = QTR; PERT_B = M_QTR;
    start_run(16'd3, HALF, ONE);
    do_iter(QTR, M_QTR, ONE, 64'd0, 0, 1'b0, 16'd1, 1'b0);
    do_iter(M_8TH, HALF, 64'd0, ONE, 0, 1'b1, 16'd2, 1'b0);
    do_iter(HALF, M_8TH, 2 * ONE, HALF, 1, 1'b0, 16'd3, 1'b1);
    tick;
    chk("run3_single_done", 64'(done_cnt - dc0), 64'd1);

    // n_iter==0 start: done next cycle, never busy, state untouched.
    ua_keep = U_A;
    n_iter = 16'd0; u_init = 64'h0ABC_0000_0000_0000; start = 1'b1;
    tick;
    start = 1'b0;
    chk("zero_done", {63'b0, done}, 64'd1);
    chk("zero_busy", {63'b0, busy}, 64'd0);
    chk("zero_u_a", U_A, ua_keep);
    chk("zero_iter", {48'b0, iter_cnt}, 64'd3);
    tick;
    chk("zero_done_drop", {63'b0, done}, 64'd0);
    chk("zero_busy2", {63'b0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
